// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the pipelined bitwise logic unit.
//   OP_W            : opcode width
//   OP_AND..OP_PASSB: 3-bit function-select encodings
// Optional feature macro used by the top level: LOGIC_UNIT_FLAGS_EN
// -----------------------------------------------------------------------------
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'd0;
    localparam logic [OP_W-1:0] OP_OR    = 3'd1;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASSB = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// -----------------------------------------------------------------------------
// logic_unit_core
// Purely combinational bitwise function unit.
// Ports:
//   op [OP_W-1:0]  : function select (logic_unit_pkg encodings)
//   a  [WIDTH-1:0] : operand A
//   b  [WIDTH-1:0] : operand B
//   y  [WIDTH-1:0] : result
// -----------------------------------------------------------------------------
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Bitwise function select
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NOTA:  y = ~a;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_PASSB: y = b;
            default:  y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Two-stage, valid/ready pipelined bitwise logic unit with a result
// accumulator that can replace operand A.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready is combinational from
//                          out_ready through the advance chain)
//   op, a, b             : function select and operands
//   acc_sel              : use accumulator instead of a for this transaction
//   acc_clr              : pulse, clears accumulator at the next edge
//   out_valid / out_ready: output handshake
//   y                    : registered result
//   y_zero, y_par        : registered zero / parity flags of y
//                          (present only when LOGIC_UNIT_FLAGS_EN is defined)
// -----------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
    output logic             y_zero,
    output logic             y_par,
`endif
    output logic [WIDTH-1:0] y
);

`ifdef LOGIC_UNIT_FLAGS_EN
    function automatic logic zero_f(input logic [WIDTH-1:0] v);
        return ~|v;
    endfunction

    function automatic logic par_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic zero_q, zero_d;
    logic par_q,  par_d;
`endif

    logic             s1_v_q,       s1_v_d;
    logic [OP_W-1:0]  s1_op_q,      s1_op_d;
    logic [WIDTH-1:0] s1_a_q,       s1_a_d;
    logic [WIDTH-1:0] s1_b_q,       s1_b_d;
    logic             s1_acc_sel_q, s1_acc_sel_d;
    logic             s2_v_q,       s2_v_d;
    logic [WIDTH-1:0] y_q,          y_d;
    logic [WIDTH-1:0] acc_q,        acc_d;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] res_s;

    assign s2_adv_s = !s2_v_q || out_ready;
    assign s1_adv_s = !s1_v_q || s2_adv_s;

    // acc is read at compute time so a back-to-back acc_sel sees the
    // result that is being written into S2 on the same edge as it enters S1.
    assign opa_s = s1_acc_sel_q ? acc_q : s1_a_q;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op (s1_op_q),
        .a  (opa_s),
        .b  (s1_b_q),
        .y  (res_s)
    );

    // Next-state for both stages and the accumulator
    always_comb begin
        s1_v_d       = s1_v_q;
        s1_op_d      = s1_op_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_acc_sel_d = s1_acc_sel_q;
        s2_v_d       = s2_v_q;
        y_d          = y_q;
        acc_d        = acc_q;
`ifdef LOGIC_UNIT_FLAGS_EN
        zero_d       = zero_q;
        par_d        = par_q;
`endif
        if (s1_adv_s) begin
            s1_v_d       = in_valid;
            s1_op_d      = op;
            s1_a_d       = a;
            s1_b_d       = b;
            s1_acc_sel_d = acc_sel;
        end else begin
            s1_v_d       = s1_v_q;
        end

        if (s2_adv_s) begin
            s2_v_d = s1_v_q;
            // Only a real transaction updates result and accumulator;
            // a bubble must not disturb the chain value.
            if (s1_v_q) begin
                y_d    = res_s;
                acc_d  = res_s;
`ifdef LOGIC_UNIT_FLAGS_EN
                zero_d = zero_f(res_s);
                par_d  = par_f(res_s);
`endif
            end else begin
                y_d    = y_q;
            end
        end else begin
            s2_v_d = s2_v_q;
        end

        // Clear wins over a simultaneous load; y still takes the result.
        if (acc_clr) begin
            acc_d = {WIDTH{1'b0}};
        end else begin
            acc_d = acc_d;
        end
    end

    // Pipeline and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q       <= 1'b0;
            s1_op_q      <= {OP_W{1'b0}};
            s1_a_q       <= {WIDTH{1'b0}};
            s1_b_q       <= {WIDTH{1'b0}};
            s1_acc_sel_q <= 1'b0;
            s2_v_q       <= 1'b0;
            y_q          <= {WIDTH{1'b0}};
            acc_q        <= {WIDTH{1'b0}};
`ifdef LOGIC_UNIT_FLAGS_EN
            zero_q       <= 1'b1;
            par_q        <= 1'b0;
`endif
        end else begin
            s1_v_q       <= s1_v_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_acc_sel_q <= s1_acc_sel_d;
            s2_v_q       <= s2_v_d;
            y_q          <= y_d;
            acc_q        <= acc_d;
`ifdef LOGIC_UNIT_FLAGS_EN
            zero_q       <= zero_d;
            par_q        <= par_d;
`endif
        end
    end

    assign in_ready  = s1_adv_s;
    assign out_valid = s2_v_q;
    assign y         = y_q;
`ifdef LOGIC_UNIT_FLAGS_EN
    assign y_zero    = zero_q;
    assign y_par     = par_q;
`endif

endmodule
